// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types and default constants for the CPU run/dump sequencer.
// Optional halt support is compiled in with the CPU_RUN_CTRL_HALT_EN macro.
package cpu_run_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StReset = 3'd1,
        StRun   = 3'd2,
        StDump  = 3'd3,
        StDone  = 3'd4
    } state_e;

    localparam int unsigned DefRstCycles = 1;
    localparam int unsigned DefRunCycles = 110;
    localparam int unsigned DefNregs     = 32;

    // Width needed to hold values 0..n-1, never less than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cpu_run_timer.sv
// Phase timer for the run sequencer: a down counter timing the core reset
// phase and an up counter timing the run phase (exported as cycle_count).
module cpu_run_timer
    import cpu_run_ctrl_pkg::*;
#(
    parameter int unsigned RST_CYCLES = DefRstCycles,
    parameter int unsigned RUN_CYCLES = DefRunCycles,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_rst_phase,
    input  logic             i_run_phase,
    output logic             o_rst_tc,
    output logic             o_run_tc,
    output logic [CNT_W-1:0] o_cycle_count
);

    localparam int unsigned RW = idx_width(RST_CYCLES);

    logic [RW-1:0]    r_rst_cnt;
    logic [CNT_W-1:0] r_cycle_cnt;

    // Load on run start, then count reset cycles down and run cycles up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_cnt   <= '0;
            r_cycle_cnt <= '0;
        end else if (i_start) begin
            r_rst_cnt   <= RW'(RST_CYCLES - 1);
            r_cycle_cnt <= '0;
        end else begin
            if (i_rst_phase && (r_rst_cnt != '0)) begin
                r_rst_cnt <= r_rst_cnt - 1'b1;
            end
            // Saturate so the count can never pass the run limit.
            if (i_run_phase && (r_cycle_cnt != CNT_W'(RUN_CYCLES))) begin
                r_cycle_cnt <= r_cycle_cnt + 1'b1;
            end
        end
    end

    // Terminal counts: last reset cycle, and the run cycle that hits the limit.
    always_comb begin
        o_rst_tc      = (r_rst_cnt == '0);
        o_run_tc      = (r_cycle_cnt == CNT_W'(RUN_CYCLES - 1));
        o_cycle_count = r_cycle_cnt;
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/dump sequencer: holds the core in reset, runs it for a bounded number
// of cycles (or until halt), then streams the register file over valid/ready.
// Define CPU_RUN_CTRL_HALT_EN to honour the halt input.
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned NREGS      = DefNregs,
    parameter int unsigned RST_CYCLES = DefRstCycles,
    parameter int unsigned RUN_CYCLES = DefRunCycles,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned ADDR_W     = idx_width(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              halt,
    output logic              cpu_rst_n,
    output logic [ADDR_W-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_idx,
    output logic [DATA_W-1:0] dump_data,
    output logic [CNT_W-1:0]  cycle_count,
    output logic              halted,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NREGS - 1);

    state_e            r_state;
    logic              r_cpu_rst_n;
    logic              r_dump_valid;
    logic [ADDR_W-1:0] r_dump_idx;
    logic              r_halted;
    logic              r_done;

    logic              w_start_acc;
    logic              w_rst_phase;
    logic              w_run_phase;
    logic              w_rst_tc;
    logic              w_run_tc;
    logic              w_halt;

`ifdef CPU_RUN_CTRL_HALT_EN
    assign w_halt = halt;
`else
    // Halt port kept for a uniform interface; masked off in this build.
    assign w_halt = halt & 1'b0;
`endif

    // Phase decode feeding the shared timer.
    always_comb begin
        w_start_acc = start && ((r_state == StIdle) || (r_state == StDone));
        w_rst_phase = (r_state == StReset);
        w_run_phase = (r_state == StRun);
    end

    cpu_run_timer #(
        .RST_CYCLES (RST_CYCLES),
        .RUN_CYCLES (RUN_CYCLES),
        .CNT_W      (CNT_W)
    ) u_timer (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_start       (w_start_acc),
        .i_rst_phase   (w_rst_phase),
        .i_run_phase   (w_run_phase),
        .o_rst_tc      (w_rst_tc),
        .o_run_tc      (w_run_tc),
        .o_cycle_count (cycle_count)
    );

    // Sequencer FSM with all control outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_cpu_rst_n  <= 1'b0;
            r_dump_valid <= 1'b0;
            r_dump_idx   <= '0;
            r_halted     <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle, StDone: begin
                    if (start) begin
                        r_state     <= StReset;
                        r_cpu_rst_n <= 1'b0;
                        r_dump_idx  <= '0;
                        r_halted    <= 1'b0;
                        r_done      <= 1'b0;
                    end
                end
                StReset: begin
                    if (w_rst_tc) begin
                        r_state     <= StRun;
                        r_cpu_rst_n <= 1'b1;
                    end
                end
                StRun: begin
                    // Halt and timeout on the same cycle resolve to one exit.
                    if (w_halt || w_run_tc) begin
                        r_state      <= StDump;
                        r_dump_valid <= 1'b1;
                        r_halted     <= w_halt;
                    end
                end
                StDump: begin
                    if (dump_ready) begin
                        if (r_dump_idx == LastIdx) begin
                            r_state      <= StDone;
                            r_dump_valid <= 1'b0;
                            r_done       <= 1'b1;
                        end else begin
                            r_dump_idx <= r_dump_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    // Output mapping; dump_data is the only combinational path.
    always_comb begin
        cpu_rst_n  = r_cpu_rst_n;
        dump_valid = r_dump_valid;
        dump_idx   = r_dump_idx;
        rf_raddr   = r_dump_idx;
        dump_data  = rf_rdata;
        halted     = r_halted;
        done       = r_done;
    end

endmodule
